// File: rtl/aes_mc_pkg.sv
// Shared GF(2^8) helpers, mode encoding and lane-count legality for the
// MixColumns datapath.
package aes_mc_pkg;

    typedef enum logic {
        MC_FWD = 1'b0,
        MC_INV = 1'b1
    } mc_mode_e;

    // Bit n set means LANES = n is legal (1, 2, 4).
    localparam logic [4:0] MC_LANES_LEGAL = 5'b10110;

    function automatic bit lanes_legal(input int unsigned lanes);
        return (lanes <= 4) && MC_LANES_LEGAL[lanes];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant; covers every MixColumns coefficient.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] x2, x4, x8, r;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        r  = 8'h00;
        if (b[0]) r = r ^ a;
        if (b[1]) r = r ^ x2;
        if (b[2]) r = r ^ x4;
        if (b[3]) r = r ^ x8;
        return r;
    endfunction

endpackage

// File: rtl/mixcolumn_word.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column, with bypass.
module mixcolumn_word
    import aes_mc_pkg::*;
(
    input  logic [31:0] col,
    input  mc_mode_e    mode,
    input  logic        bypass,
    output logic [31:0] res
);

    logic [3:0] coef [4];
    logic [7:0] a    [4];
    logic [7:0] r    [4];

    // Row i uses the base coefficient row rotated right by i.
    always_comb begin
        if (mode == MC_INV) begin
            coef[0] = 4'he; coef[1] = 4'hb; coef[2] = 4'hd; coef[3] = 4'h9;
        end else begin
            coef[0] = 4'h2; coef[1] = 4'h3; coef[2] = 4'h1; coef[3] = 4'h1;
        end
        for (int j = 0; j < 4; j++) begin
            a[j] = col[8*j +: 8];
        end
        for (int i = 0; i < 4; i++) begin
            r[i] = 8'h00;
            for (int j = 0; j < 4; j++) begin
                r[i] = r[i] ^ gmul(a[j], coef[(j - i) & 3]);
            end
        end
        if (bypass) begin
            res = col;
        end else begin
            res = {r[3], r[2], r[1], r[0]};
        end
    end

endmodule

// File: rtl/mixcolumn_stream.sv
// Streaming MixColumns: assembles a column from LANES-byte beats, transforms
// it and presents it through a one-deep registered output with handshake.
module mixcolumn_stream
    import aes_mc_pkg::*;
#(
    parameter int unsigned LANES  = 1,
    parameter bit          INV_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_mode,
    input  logic               in_bypass,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [1:0]         out_col
);

    if (!lanes_legal(LANES)) begin : g_bad_lanes
        $error("mixcolumn_stream: LANES must be 1, 2 or 4");
    end

    localparam int unsigned BEATS = (LANES == 0) ? 4 : 4 / LANES;
    localparam int unsigned W     = 8 * LANES;

    logic [1:0]  beat_q;
    logic [31:0] col_q;
    mc_mode_e    mode_q;
    logic        bypass_q;
    logic        out_valid_q;
    logic [31:0] out_data_q;
    logic [1:0]  out_col_q;
    logic [1:0]  col_cnt_q;

    logic        is_first;
    logic        is_last;
    logic        accept;
    logic [31:0] col_next;
    mc_mode_e    mode_sel;
    logic        bypass_sel;
    logic [31:0] mix_res;

    // Handshake, byte insertion and first-beat mode/bypass selection.
    always_comb begin
        is_first = (beat_q == 2'd0);
        is_last  = (beat_q == 2'(BEATS - 1));
        in_ready = rst & (~is_last | ~out_valid_q | out_ready);
        accept   = in_valid & in_ready;
        col_next = col_q;
        col_next[int'(beat_q) * W +: W] = in_data;
        if (!INV_EN) begin
            mode_sel = MC_FWD;
        end else if (is_first) begin
            mode_sel = mc_mode_e'(in_mode);
        end else begin
            mode_sel = mode_q;
        end
        bypass_sel = is_first ? in_bypass : bypass_q;
    end

    mixcolumn_word u_word (
        .col    (col_next),
        .mode   (mode_sel),
        .bypass (bypass_sel),
        .res    (mix_res)
    );

    // Beat counter, column assembly and output register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            beat_q      <= 2'd0;
            col_q       <= 32'h0;
            mode_q      <= MC_FWD;
            bypass_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
            out_col_q   <= 2'd0;
            col_cnt_q   <= 2'd0;
        end else begin
            if (accept) begin
                col_q <= col_next;
                if (is_first) begin
                    mode_q   <= mode_sel;
                    bypass_q <= bypass_sel;
                end
                beat_q <= is_last ? 2'd0 : beat_q + 2'd1;
            end
            if (accept && is_last) begin
                out_data_q  <= mix_res;
                out_valid_q <= 1'b1;
                out_col_q   <= col_cnt_q;
                col_cnt_q   <= col_cnt_q + 2'd1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_col   = out_col_q;

endmodule

// File: tb/tb_mixcolumn_stream.sv
// Directed bench for mixcolumn_stream at LANES = 1, 2 and 4.
module tb_mixcolumn_stream;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // LANES=1 instance
    logic        v1 = 0, m1 = 0, b1 = 0, or1 = 1;
    logic [7:0]  d1 = 0;
    logic        r1, ov1;
    logic [31:0] od1;
    logic [1:0]  oc1;
    // LANES=2 instance
    logic        v2 = 0, m2 = 0, b2 = 0, or2 = 1;
    logic [15:0] d2 = 0;
    logic        r2, ov2;
    logic [31:0] od2;
    logic [1:0]  oc2;
    // LANES=4 instance
    logic        v4 = 0, m4 = 0, b4 = 0, or4 = 1;
    logic [31:0] d4 = 0;
    logic        r4, ov4;
    logic [31:0] od4;
    logic [1:0]  oc4;

    int vectors = 0;
    int errs    = 0;

    mixcolumn_stream #(.LANES(1), .INV_EN(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1), .in_mode(m1),
        .in_bypass(b1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_col(oc1)
    );
    mixcolumn_stream #(.LANES(2), .INV_EN(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_data(d2), .in_mode(m2),
        .in_bypass(b2), .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_col(oc2)
    );
    mixcolumn_stream #(.LANES(4), .INV_EN(1)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .in_data(d4), .in_mode(m4),
        .in_bypass(b4), .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_col(oc4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Each send is entered on a negedge and returns on the negedge after acceptance.
    task automatic send1(input logic [7:0] b, input logic m, input logic byp);
        int n = 0;
        v1 = 1; d1 = b; m1 = m; b1 = byp;
        #1;
        while (!r1 && n < 50) begin @(negedge clk); n++; end
        chk("l1_in_ready", {31'b0, r1}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        v1 = 0;
    endtask

    task automatic send2(input logic [15:0] b, input logic m, input logic byp);
        int n = 0;
        v2 = 1; d2 = b; m2 = m; b2 = byp;
        #1;
        while (!r2 && n < 50) begin @(negedge clk); n++; end
        chk("l2_in_ready", {31'b0, r2}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        v2 = 0;
    endtask

    task automatic send4(input logic [31:0] b, input logic m, input logic byp);
        int n = 0;
        v4 = 1; d4 = b; m4 = m; b4 = byp;
        #1;
        while (!r4 && n < 50) begin @(negedge clk); n++; end
        chk("l4_in_ready", {31'b0, r4}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        v4 = 0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  {31'b0, r1}, 32'd0);
        chk("rst_out_valid", {31'b0, ov1}, 32'd0);
        chk("rst_out_data",  od4, 32'h0);
        chk("rst_out_col",   {30'b0, oc2}, 32'd0);
        rst = 1;

        // LANES=1 forward: db,13,53,45 -> 8e,4d,a1,bc
        send1(8'hdb, 0, 0);
        send1(8'h13, 0, 0);
        send1(8'h53, 0, 0);
        chk("l1_valid_before_last", {31'b0, ov1}, 32'd0);
        send1(8'h45, 0, 0);
        chk("l1_fwd_valid", {31'b0, ov1}, 32'd1);
        chk("l1_fwd_data",  od1, 32'hbca14d8e);
        chk("l1_fwd_col",   {30'b0, oc1}, 32'd0);
        @(negedge clk);
        chk("l1_valid_cleared", {31'b0, ov1}, 32'd0);

        // LANES=4 inverse then forward, back to back
        send4(32'hbca14d8e, 1, 0);
        chk("l4_inv_data", od4, 32'h455313db);
        chk("l4_inv_col",  {30'b0, oc4}, 32'd0);
        send4(32'h5c220af2, 0, 0);
        chk("l4_fwd_valid", {31'b0, ov4}, 32'd1);
        chk("l4_fwd_data",  od4, 32'h9d58dc9f);
        chk("l4_fwd_col",   {30'b0, oc4}, 32'd1);

        // LANES=2 forward; in_mode toggled on second beat must be ignored
        send2(16'hd4d4, 0, 0);
        send2(16'hd5d4, 1, 0);
        chk("l2_col0_data", od2, 32'hd6d7d5d5);
        chk("l2_col0_col",  {30'b0, oc2}, 32'd0);
        send2(16'h262d, 0, 0);
        send2(16'h4c31, 1, 0);
        chk("l2_col1_data", od2, 32'hf8bd7e4d);
        chk("l2_col1_col",  {30'b0, oc2}, 32'd1);

        // LANES=1 bypass with downstream stalled
        or1 = 0;
        send1(8'hc6, 0, 1);
        send1(8'hc6, 0, 0);
        send1(8'hc6, 0, 0);
        send1(8'hc6, 0, 0);
        chk("byp_data", od1, 32'hc6c6c6c6);
        chk("byp_col",  {30'b0, oc1}, 32'd1);
        // Bypass latched on first beat only; later beats drive bypass=0
        send1(8'hdb, 0, 1);
        send1(8'h13, 0, 0);
        send1(8'h53, 0, 0);
        v1 = 1; d1 = 8'h45; m1 = 0; b1 = 0;
        #1;
        chk("stall_in_ready", {31'b0, r1}, 32'd0);
        repeat (2) @(negedge clk);
        chk("stall_valid", {31'b0, ov1}, 32'd1);
        chk("stall_data",  od1, 32'hc6c6c6c6);
        chk("stall_col",   {30'b0, oc1}, 32'd1);
        or1 = 1;
        #1;
        chk("unstall_in_ready", {31'b0, r1}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        v1 = 0;
        chk("byp2_valid", {31'b0, ov1}, 32'd1);
        chk("byp2_data",  od1, 32'h455313db);
        chk("byp2_col",   {30'b0, oc1}, 32'd2);

        // Reset mid-column discards partial bytes
        send1(8'haa, 0, 0);
        send1(8'hbb, 0, 0);
        rst = 0;
        @(negedge clk);
        chk("midrst_in_ready",  {31'b0, r1}, 32'd0);
        chk("midrst_out_valid", {31'b0, ov1}, 32'd0);
        chk("midrst_out_data",  od1, 32'h0);
        rst = 1;
        send1(8'h01, 0, 0);
        send1(8'h01, 0, 0);
        send1(8'h01, 0, 0);
        send1(8'h01, 0, 0);
        chk("post_rst_data", od1, 32'h01010101);
        chk("post_rst_col",  {30'b0, oc1}, 32'd0);

        // LANES=4: five back-to-back columns, no bubbles, col wraps
        for (int i = 0; i < 5; i++) begin
            v4 = 1; m4 = 0; b4 = 0;
            d4 = (i % 2) ? 32'h455313db : 32'h01010101;
            #1;
            chk("b2b_in_ready", {31'b0, r4}, 32'd1);
            @(posedge clk);
            @(negedge clk);
            chk("b2b_valid", {31'b0, ov4}, 32'd1);
            chk("b2b_col",   {30'b0, oc4}, 32'(i % 4));
            chk("b2b_data",  od4, (i % 2) ? 32'hbca14d8e : 32'h01010101);
        end
        v4 = 0;
        @(negedge clk);
        chk("b2b_drained", {31'b0, ov4}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/mixcolumn_stream.md
MIXCOLUMN_STREAM -- requirements
Module: mixcolumn_stream

Interface
REQ-001 SHALL have parameter LANES, default 1: bytes accepted per input beat; legal values 1, 2, 4; any other value is an elaboration error.
REQ-002 SHALL have parameter INV_EN, default 1: 1 enables InvMixColumns; 0 forces the forward transform and ignores in_mode.
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an input beat is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-007 SHALL have port in_data, input, 8*LANES bits: column bytes; bits [7:0] carry the lowest-index byte of the beat.
REQ-008 SHALL have port in_mode, input, 1 bit: 0 selects MixColumns, 1 selects InvMixColumns.
REQ-009 SHALL have port in_bypass, input, 1 bit: 1 passes the column through unmixed (final round).
REQ-010 SHALL have port out_valid, output, 1 bit: the output column is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream block accepts the output column.
REQ-012 SHALL have port out_data, output, 32 bits: result column; bits [7:0] = r0 through [31:24] = r3.
REQ-013 SHALL have port out_col, output, 2 bits: column index within the state (0..3).

Function
REQ-014 SHALL accept a beat only when in_valid=1 and in_ready=1 in the same cycle.
REQ-015 SHALL assemble one column from 4/LANES accepted beats, filling bytes a0..a3 in ascending order, tracked by a beat counter.
REQ-016 SHALL latch in_mode and in_bypass on the first beat of a column; changes on later beats of that column have no effect.
REQ-017 SHALL drive in_ready=1 when the next beat is not the final beat of a column, or when out_valid=0, or when out_ready=1.
REQ-018 SHALL compute the forward transform with xtime(a) = (a<<1) ^ (a[7] ? 0x1B : 0): r0=2a0^3a1^a2^a3, r1=a0^2a1^3a2^a3, r2=a0^a1^2a2^3a3, r3=3a0^a1^a2^2a3.
REQ-019 SHALL compute the inverse transform with coefficients row-rotated from {0E,0B,0D,09}: r0=E·a0^B·a1^D·a2^9·a3, with each following row rotated right by one.
REQ-020 SHALL load the result into the output register and set out_valid=1 on the clock edge that accepts the final beat, giving one-cycle latency from that beat.
REQ-021 SHALL hold out_data and out_col stable while out_valid=1 and out_ready=0.
REQ-022 SHALL clear out_valid on an edge where out_valid=1 and out_ready=1, unless a final beat is accepted on the same edge, in which case the new column loads and out_valid stays 1.
REQ-023 SHALL increment out_col by 1 per produced column, wrapping 3 to 0.
REQ-024 SHALL sustain one column per 4/LANES cycles when in_valid=1 and out_ready=1 continuously.

Reset
REQ-025 SHALL, while rst=0 at a clock edge, set beat counter=0, out_col=0, out_valid=0, out_data=0x00000000, and latched mode and bypass=0.
REQ-026 SHALL discard any partial column on reset mid-operation; the first beat after rst=1 is byte a0 of column 0.
REQ-027 SHALL drive in_ready=0 during any cycle in which rst=0.

Structure
REQ-028 SHALL take from the shared package aes_mc_pkg: the xtime and gmul functions, the mode enum (MC_FWD=0, MC_INV=1), and the legal-LANES constant and check.
REQ-029 SHALL instantiate exactly one combinational sub-module, mixcolumn_word (32-bit in, mode, bypass, 32-bit out); all sequencing and handshake logic stays in mixcolumn_stream.

Verification
REQ-030 SHALL be checked with: LANES=1, fwd, bytes db,13,53,45 -> out_data bytes r0..r3 = 8e,4d,a1,bc, out_col=0, out_valid one cycle after the 4th beat.
REQ-031 SHALL be checked with: LANES=4, inv, column 8e,4d,a1,bc -> db,13,53,45; then fwd f2,0a,22,5c -> 9f,dc,58,9d with out_col=1.
REQ-032 SHALL be checked with: LANES=2, fwd, d4,d4,d4,d5 and then 2d,26,31,4c -> d5,d5,d7,d6 and then 4d,7e,bd,f8; in_mode toggled on the 2nd beat has no effect.
REQ-033 SHALL be checked with: in_bypass=1, column c6,c6,c6,c6 -> c6,c6,c6,c6; with out_ready=0 held, the output stays stable and in_ready=0 on the final beat of the next column.
REQ-034 SHALL be checked with: reset asserted after 2 of 4 beats (LANES=1), then a full column 01,01,01,01 -> 01,01,01,01 with out_col=0.
REQ-035 SHALL be checked with: 5 back-to-back columns with out_ready=1 -> out_col sequence 0,1,2,3,0 and no bubbles at LANES=4.
